// File: rtl/aes_iter_ctrl_pkg.sv
// Shared types, constants and AES byte-level helpers for the iterative AES-128 controller
// and its combinational round datapath.
package aes_iter_ctrl_pkg;

    localparam int NR        = 10;
    localparam int AES_BLK_W = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        LAST  = 2'd2,
        DONE  = 2'd3
    } aes_fsm_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end else begin
                p = p;
            end
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254, which also maps 0 to 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) begin
            o[8*i +: 8] = sbox(s[8*i +: 8]);
        end
        return o;
    endfunction

    // Byte i of the block sits at bits [127-8i -: 8]; column c holds bytes 4c..4c+3
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [3:0] rnd);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rcon(rnd), 24'h000000};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

endpackage

// File: rtl/add_round_keys.sv
// Initial AddRoundKey: whitening of the plaintext with the cipher key.
module add_round_keys
    import aes_iter_ctrl_pkg::*;
(
    input  logic [AES_BLK_W-1:0] state_in,
    input  logic [AES_BLK_W-1:0] key_in,
    output logic [AES_BLK_W-1:0] state_out
);

    assign state_out = state_in ^ key_in;

endmodule

// File: rtl/lastround.sv
// Final AES round: identical to a normal round but without MixColumns.
module lastround
    import aes_iter_ctrl_pkg::*;
(
    input  logic [AES_BLK_W-1:0] state_in,
    input  logic [3:0]           rnd,
    input  logic [AES_BLK_W-1:0] key_in,
    output logic [AES_BLK_W-1:0] state_out,
    output logic [AES_BLK_W-1:0] key_out
);

    assign key_out   = key_step(key_in, rnd);
    assign state_out = shift_rows(sub_bytes(state_in)) ^ key_out;

endmodule

// File: rtl/round.sv
// One full AES round (SubBytes, ShiftRows, MixColumns, AddRoundKey) plus the matching
// key-schedule step; purely combinational.
module round
    import aes_iter_ctrl_pkg::*;
(
    input  logic [AES_BLK_W-1:0] state_in,
    input  logic [3:0]           rnd,
    input  logic [AES_BLK_W-1:0] key_in,
    output logic [AES_BLK_W-1:0] state_out,
    output logic [AES_BLK_W-1:0] key_out
);

    assign key_out   = key_step(key_in, rnd);
    assign state_out = mix_columns(shift_rows(sub_bytes(state_in))) ^ key_out;

endmodule

// File: rtl/aes_iter_ctrl.sv
// Iterative AES-128 encryptor control: one round per clock, valid/ready job handshake,
// abort, and a held result register pair (cipher_text/keyout).
module aes_iter_ctrl
    import aes_iter_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] plaintext,
    input  logic [AES_BLK_W-1:0] key,
    input  logic                 abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] cipher_text,
    output logic [AES_BLK_W-1:0] keyout,
    output logic                 busy
);

    aes_fsm_e             fsm_r, fsm_nxt_s;
    logic [3:0]           rnd_r, rnd_nxt_s;
    logic [AES_BLK_W-1:0] data_r, data_nxt_s;
    logic [AES_BLK_W-1:0] key_r, key_nxt_s;
    logic [AES_BLK_W-1:0] cipher_nxt_s, keyout_nxt_s;
    logic                 out_valid_nxt_s;
    logic [AES_BLK_W-1:0] ark_s, rnd_state_s, rnd_key_s, last_state_s, last_key_s;

    add_round_keys u_ark (
        .state_in  (plaintext),
        .key_in    (key),
        .state_out (ark_s)
    );

    round u_round (
        .state_in  (data_r),
        .rnd       (rnd_r),
        .key_in    (key_r),
        .state_out (rnd_state_s),
        .key_out   (rnd_key_s)
    );

    lastround u_lastround (
        .state_in  (data_r),
        .rnd       (4'hA),
        .key_in    (key_r),
        .state_out (last_state_s),
        .key_out   (last_key_s)
    );

    assign in_ready = (fsm_r == IDLE);
    assign busy     = (fsm_r != IDLE);

    // Next-state and next-datapath selection; abort wins over every other action
    always_comb begin
        fsm_nxt_s       = fsm_r;
        rnd_nxt_s       = rnd_r;
        data_nxt_s      = data_r;
        key_nxt_s       = key_r;
        cipher_nxt_s    = cipher_text;
        keyout_nxt_s    = keyout;
        out_valid_nxt_s = out_valid;
        case (fsm_r)
            IDLE: begin
                if (!abort && in_valid) begin
                    data_nxt_s = ark_s;
                    key_nxt_s  = key;
                    rnd_nxt_s  = 4'd1;
                    fsm_nxt_s  = ROUND;
                end else begin
                    fsm_nxt_s = IDLE;
                end
            end
            ROUND: begin
                if (abort) begin
                    fsm_nxt_s = IDLE;
                end else begin
                    data_nxt_s = rnd_state_s;
                    key_nxt_s  = rnd_key_s;
                    rnd_nxt_s  = rnd_r + 4'd1;
                    if (rnd_r == 4'(NR - 1)) begin
                        fsm_nxt_s = LAST;
                    end else begin
                        fsm_nxt_s = ROUND;
                    end
                end
            end
            LAST: begin
                if (abort) begin
                    fsm_nxt_s = IDLE;
                end else begin
                    cipher_nxt_s    = last_state_s;
                    keyout_nxt_s    = last_key_s;
                    out_valid_nxt_s = 1'b1;
                    fsm_nxt_s       = DONE;
                end
            end
            DONE: begin
                if (out_ready || abort) begin
                    out_valid_nxt_s = 1'b0;
                    fsm_nxt_s       = IDLE;
                end else begin
                    fsm_nxt_s = DONE;
                end
            end
            default: begin
                out_valid_nxt_s = 1'b0;
                fsm_nxt_s       = IDLE;
            end
        endcase
    end

    // State, round counter, working registers and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_r       <= IDLE;
            rnd_r       <= 4'd0;
            data_r      <= '0;
            key_r       <= '0;
            cipher_text <= '0;
            keyout      <= '0;
            out_valid   <= 1'b0;
        end else begin
            fsm_r       <= fsm_nxt_s;
            rnd_r       <= rnd_nxt_s;
            data_r      <= data_nxt_s;
            key_r       <= key_nxt_s;
            cipher_text <= cipher_nxt_s;
            keyout      <= keyout_nxt_s;
            out_valid   <= out_valid_nxt_s;
        end
    end

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// Directed bench for aes_iter_ctrl using FIPS-197 vectors, handshake stalls, abort and reset.
module tb_aes_iter_ctrl;

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KO_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KO_C  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic         clk, rst_n, in_valid, in_ready, abort, out_valid, out_ready, busy;
    logic [127:0] plaintext, key, cipher_text, keyout;
    int           n_checks, n_fail, lat, seen;

    aes_iter_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .plaintext   (plaintext),
        .key         (key),
        .abort       (abort),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .cipher_text (cipher_text),
        .keyout      (keyout),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Offer a job and step past its accept edge
    task automatic launch(input logic [127:0] p, input logic [127:0] k);
        plaintext = p;
        key       = k;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("accept_busy", {127'd0, busy}, 128'd1);
    endtask

    // Count edges until out_valid; optionally disturb the inputs while rounds run
    task automatic wait_result(input bit disturb, output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (disturb && n == 3) begin
                in_valid  = 1'b1;
                plaintext = 128'hffeeddccbbaa99887766554433221100;
                key       = 128'h0f0e0d0c0b0a09080706050403020100;
            end
            if (disturb && n == 5) begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("hs_out_valid", {127'd0, out_valid}, 128'd0);
        chk("hs_busy", {127'd0, busy}, 128'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        abort     = 1'b0;
        plaintext = '0;
        key       = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_cipher", cipher_text, 128'd0);
        chk("rst_keyout", keyout, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // App B vector, inputs disturbed while rounds run
        launch(PT_B, KEY_B);
        wait_result(1'b1, lat);
        chk("b_latency", 128'(lat), 128'd10);
        chk("b_cipher", cipher_text, CT_B);
        chk("b_keyout", keyout, KO_B);
        chk("b_in_ready_done", {127'd0, in_ready}, 128'd0);
        handshake();
        chk("b_cipher_retained", cipher_text, CT_B);
        chk("b_in_ready_idle", {127'd0, in_ready}, 128'd1);

        // App C.1 vector with a 5-cycle consumer stall and new inputs offered meanwhile
        launch(PT_C, KEY_C);
        wait_result(1'b0, lat);
        chk("c_latency", 128'(lat), 128'd10);
        chk("c_cipher", cipher_text, CT_C);
        chk("c_keyout", keyout, KO_C);
        in_valid  = 1'b1;
        plaintext = PT_B;
        key       = KEY_B;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall_out_valid", {127'd0, out_valid}, 128'd1);
            chk("stall_in_ready", {127'd0, in_ready}, 128'd0);
            chk("stall_cipher", cipher_text, CT_C);
            chk("stall_keyout", keyout, KO_C);
        end
        in_valid = 1'b0;
        handshake();

        // Back-to-back jobs with in_valid and out_ready held high
        plaintext = PT_B;
        key       = KEY_B;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bb1_busy", {127'd0, busy}, 128'd1);
        wait_result(1'b0, lat);
        chk("bb1_latency", 128'(lat), 128'd10);
        chk("bb1_cipher", cipher_text, CT_B);
        plaintext = PT_C;
        key       = KEY_C;
        @(posedge clk);
        #1;
        chk("bb_hs_out_valid", {127'd0, out_valid}, 128'd0);
        chk("bb_hs_in_ready", {127'd0, in_ready}, 128'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bb2_accept", {127'd0, busy}, 128'd1);
        wait_result(1'b0, lat);
        chk("bb2_latency", 128'(lat), 128'd10);
        chk("bb2_cipher", cipher_text, CT_C);
        chk("bb2_keyout", keyout, KO_C);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bb2_idle", {127'd0, busy}, 128'd0);

        // Abort beats accept in IDLE
        abort     = 1'b1;
        in_valid  = 1'b1;
        plaintext = PT_B;
        key       = KEY_B;
        @(posedge clk);
        #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort_idle_busy", {127'd0, busy}, 128'd0);

        // Abort with rnd == 5, then a fresh job
        launch(PT_B, KEY_B);
        repeat (4) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_busy", {127'd0, busy}, 128'd0);
        chk("abort_out_valid", {127'd0, out_valid}, 128'd0);
        chk("abort_cipher_kept", cipher_text, CT_C);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen++;
        end
        chk("abort_no_pulse", 128'(seen), 128'd0);
        launch(PT_B, KEY_B);
        wait_result(1'b0, lat);
        chk("post_abort_cipher", cipher_text, CT_B);
        chk("post_abort_keyout", keyout, KO_B);
        handshake();

        // Abort while the result waits in DONE
        launch(PT_C, KEY_C);
        wait_result(1'b0, lat);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_done_out_valid", {127'd0, out_valid}, 128'd0);
        chk("abort_done_busy", {127'd0, busy}, 128'd0);
        chk("abort_done_cipher", cipher_text, CT_C);

        // Asynchronous reset with rnd == 3
        launch(PT_B, KEY_B);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cipher", cipher_text, 128'd0);
        chk("arst_keyout", keyout, 128'd0);
        chk("arst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("arst_busy", {127'd0, busy}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_in_ready", {127'd0, in_ready}, 128'd1);
        launch(PT_C, KEY_C);
        wait_result(1'b0, lat);
        chk("post_rst_latency", 128'(lat), 128'd10);
        chk("post_rst_cipher", cipher_text, CT_C);
        handshake();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_iter_ctrl.md
AES_ITER_CTRL -- requirements
Module: aes_iter_ctrl

Interface
REQ-001 Parameter: NR, 10, number of AES-128 rounds; fixed at 10, no other value supported.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  plaintext/key offered.
REQ-005 in_ready  output  1  block can accept a new job.
REQ-006 plaintext  input  128  plaintext block (state).
REQ-007 key  input  128  AES-128 cipher key.
REQ-008 abort  input  1  synchronous cancel of the job in flight.
REQ-009 out_valid  output  1  cipher_text/keyout valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 cipher_text  output  128  registered ciphertext.
REQ-012 keyout  output  128  registered final (round-10) round key.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states SHALL be IDLE, ROUND, LAST, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; accept = in_valid && in_ready.
REQ-016 On accept: state_reg <= plaintext XOR key, key_reg <= key, rnd <= 1, IDLE->ROUND.
REQ-017 In ROUND, each cycle: state_reg <= round(state_reg, rnd, key_reg), key_reg <= that round's keyout, rnd <= rnd+1.
REQ-018 ROUND->LAST on the edge where rnd==9 is processed; rnd is 4 bits, range 1..10, never wraps.
REQ-019 In LAST: cipher_text <= lastround(state_reg, 4'hA, key_reg), keyout <= its keyout, out_valid <= 1, LAST->DONE.
REQ-020 Latency: accept edge k -> out_valid high immediately after edge k+10 (exactly 10 cycles, 9 ROUND + 1 LAST).
REQ-021 DONE: out_valid, cipher_text, keyout SHALL hold stable until out_valid && out_ready; on that edge out_valid <= 0, DONE->IDLE.
REQ-022 in_valid, plaintext, key SHALL be ignored outside IDLE; inputs need be stable only on the accept edge.
REQ-023 cipher_text/keyout SHALL retain the last result after the handshake until the next LAST cycle overwrites them.
REQ-024 abort in ROUND or LAST SHALL return to IDLE next edge, discard the job, leave out_valid 0 and cipher_text/keyout unchanged.
REQ-025 abort in DONE SHALL drop out_valid and go to IDLE; abort in IDLE SHALL have no effect, and abort takes priority over accept in the same cycle.
REQ-026 abort and out_ready in DONE in the same cycle SHALL count as a completed handshake and go to IDLE.
REQ-027 busy SHALL equal (state != IDLE), combinational from the state register.

Reset
REQ-028 rst_n low SHALL asynchronously force IDLE, rnd=0, state_reg=0, key_reg=0, cipher_text=0, keyout=0, out_valid=0.
REQ-029 Reset mid-job SHALL discard the job with no output pulse; first accept is possible on the first rising edge after rst_n rises.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, NR, and AES_BLK_W=128.
REQ-031 The block SHALL reuse the existing add_round_keys, round and lastround datapath modules, one instance each; no new sub-module.
REQ-032 Datapath instances SHALL be combinational between registers; the only sequential logic is this block.

Verification
REQ-033 FIPS-197 App B: pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c -> cipher_text 3925841d02dc09fbdc118597196a0b32, keyout d014f9a8c9ee2589e13f0cc8b6630ca6, out_valid exactly 10 cycles after accept.
REQ-034 FIPS-197 App C.1: pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> 69c4e0d86a7b0430d8cdb78070b4c55a; out_ready held 0 for 5 cycles -> outputs stable, in_ready 0 throughout.
REQ-035 Back-to-back: both vectors with in_valid held high and out_ready=1 -> two results in order, second accept on the edge after the first handshake.
REQ-036 abort at rnd==5 -> IDLE next cycle, no out_valid pulse, cipher_text unchanged; next job returns the correct result.
REQ-037 rst_n low at rnd==3 -> all outputs 0 asynchronously, in_ready 1 after release, new job correct.
REQ-038 in_valid toggled and plaintext changed during ROUND -> no effect on the result in flight.
